// File: rtl/elevator_scheduler_if.sv
// Request/status bundle between the elevator scheduler (slave) and whatever drives it (master).
interface elevator_scheduler_if #(
    parameter int FLOORS = 3
);
    logic [FLOORS-1:0] req;
    logic              hold;
    logic [FLOORS-1:0] floor;
    logic              door_open;
    logic              moving_up;
    logic              moving_down;
    logic [FLOORS-1:0] pending;

    modport master (output req, hold,
                    input  floor, door_open, moving_up, moving_down, pending);
    modport slave  (input  req, hold,
                    output floor, door_open, moving_up, moving_down, pending);
endinterface

// File: rtl/elevator_scheduler.sv
// Single-car SCAN elevator sequencer: sticky request mask, travel/door timing, one-hot position.
// Optional emergency stop input is compiled in when ELEVATOR_ESTOP_EN is defined.
module elevator_scheduler #(
    parameter int FLOORS        = 3,
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 3
) (
    input  logic clk,
    input  logic reset,
`ifdef ELEVATOR_ESTOP_EN
    input  logic estop,
`endif
    elevator_scheduler_if.slave bus
);
    localparam int MAX_CYCLES = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam int PW = $clog2(FLOORS);
    localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
    localparam logic [TW-1:0] DOOR_LOAD   = TW'(DOOR_CYCLES - 1);
    localparam logic [PW-1:0] TOP_POS     = PW'(FLOORS - 1);

    typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;

    state_t            state_reg, state_next;
    logic [PW-1:0]     pos_reg, pos_next, step_pos;
    logic              dir_reg, dir_next;
    logic [TW-1:0]     timer_reg, timer_next;
    logic [FLOORS-1:0] pending_reg, pending_next, clr_mask, eff;
    logic [FLOORS-1:0] above_mask, below_mask, above_step_mask, below_step_mask;
    logic              above, below, above_step, below_step, at_edge;

    // Requests are acted on in the cycle they are sampled, not one cycle later.
    assign eff      = pending_reg | bus.req;
    assign step_pos = dir_reg ? (pos_reg + PW'(1)) : (pos_reg - PW'(1));
    assign at_edge  = dir_reg ? (pos_reg == TOP_POS) : (pos_reg == '0);

    for (genvar gi = 0; gi < FLOORS; gi++) begin : g_floor
        assign above_mask[gi]      = eff[gi] && (gi > int'(pos_reg));
        assign below_mask[gi]      = eff[gi] && (gi < int'(pos_reg));
        assign above_step_mask[gi] = eff[gi] && (gi > int'(step_pos));
        assign below_step_mask[gi] = eff[gi] && (gi < int'(step_pos));
        assign bus.floor[gi]       = (int'(pos_reg) == gi);
    end

    assign above      = |above_mask;
    assign below      = |below_mask;
    assign above_step = |above_step_mask;
    assign below_step = |below_step_mask;

    always_comb begin
        state_next = state_reg;
        pos_next   = pos_reg;
        dir_next   = dir_reg;
        timer_next = timer_reg;
        clr_mask   = '0;
        unique case (state_reg)
            IDLE: begin
                if (eff[pos_reg]) begin
                    state_next        = DOOR;
                    clr_mask[pos_reg] = 1'b1;
                    timer_next        = DOOR_LOAD;
                end else if (above && (dir_reg || !below)) begin
                    state_next = MOVE;
                    dir_next   = 1'b1;
                    timer_next = TRAVEL_LOAD;
                end else if (below) begin
                    state_next = MOVE;
                    dir_next   = 1'b0;
                    timer_next = TRAVEL_LOAD;
                end
            end
            MOVE: begin
                if (timer_reg != '0) begin
                    timer_next = timer_reg - TW'(1);
                end else if (at_edge) begin
                    // Defensive: never step past the shaft ends.
                    state_next = IDLE;
                end else begin
                    pos_next = step_pos;
                    if (eff[step_pos]) begin
                        state_next         = DOOR;
                        clr_mask[step_pos] = 1'b1;
                        timer_next         = DOOR_LOAD;
                    end else if (dir_reg ? above_step : below_step) begin
                        timer_next = TRAVEL_LOAD;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            DOOR: begin
                if (eff[pos_reg]) begin
                    clr_mask[pos_reg] = 1'b1;
                    timer_next        = DOOR_LOAD;
                end else if (bus.hold) begin
                    timer_next = DOOR_LOAD;
                end else if (timer_reg != '0) begin
                    timer_next = timer_reg - TW'(1);
                end else if (dir_reg ? above : below) begin
                    state_next = MOVE;
                    timer_next = TRAVEL_LOAD;
                end else if (dir_reg ? below : above) begin
                    state_next = MOVE;
                    dir_next   = ~dir_reg;
                    timer_next = TRAVEL_LOAD;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
`ifdef ELEVATOR_ESTOP_EN
        // Emergency stop freezes the car but keeps collecting requests.
        if (estop) begin
            state_next = state_reg;
            pos_next   = pos_reg;
            dir_next   = dir_reg;
            timer_next = timer_reg;
            clr_mask   = '0;
        end
`endif
        pending_next = eff & ~clr_mask;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            pos_reg     <= '0;
            dir_reg     <= 1'b1;
            timer_reg   <= '0;
            pending_reg <= '0;
        end else begin
            state_reg   <= state_next;
            pos_reg     <= pos_next;
            dir_reg     <= dir_next;
            timer_reg   <= timer_next;
            pending_reg <= pending_next;
        end
    end

    assign bus.door_open = (state_reg == DOOR);
    assign bus.pending   = pending_reg;
`ifdef ELEVATOR_ESTOP_EN
    assign bus.moving_up   = (state_reg == MOVE) && dir_reg && !estop;
    assign bus.moving_down = (state_reg == MOVE) && !dir_reg && !estop;
`else
    assign bus.moving_up   = (state_reg == MOVE) && dir_reg;
    assign bus.moving_down = (state_reg == MOVE) && !dir_reg;
`endif
endmodule
